score_control: RTL

Per-player scoring and game-end controller for the two-player card game. It sits directly downstream of the answer checker: it detects each new keypad submission, samples the checker's `right` verdict, and updates the acting player's score. It declares the game finished when a player reaches the win score. Its outputs are `score_control_fin`, the winner and both scores, consumed by the LED/segment display path and the turn logic.

---
 rtl/score_pkg.sv | 33 +++
 rtl/score_counter.sv | 28 ++
 rtl/score_control.sv | 122 ++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the two-player scoring controller.
package score_pkg;

  localparam int SCORE_W = 4;
  localparam int DEF_WIN_SCORE = 5;
  localparam logic [3:0] DEF_RESTART_KEY = 4'd12;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    JUDGE,
    UPDATE,
    RELEASE,
    GAME_OVER
  } state_t;

  // Saturating single step; inc wins if both are asserted.
  function automatic logic [SCORE_W-1:0] sat_step(
    input logic [SCORE_W-1:0] v,
    input logic inc,
    input logic dec
  );
    logic [SCORE_W-1:0] r;
    r = v;
    if (inc) begin
      if (v != SCORE_MAX) r = v + 1'b1;
    end else if (dec) begin
      if (v != '0) r = v - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_counter.sv
// Saturating up/down score counter with enable and synchronous clear.
module score_counter
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  output logic [SCORE_W-1:0] count,
  output logic [SCORE_W-1:0] count_next
);

  // count_next is exposed so the controller can evaluate the win
  // condition on the same edge the score lands.
  always_comb begin
    count_next = count;
    if (clr)     count_next = '0;
    else if (en) count_next = sat_step(count, inc, dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/score_control.sv
// Per-player scoring and game-end controller; one judgement per key press.
// Optional SCORE_PENALTY_EN: a wrong verdict decrements the acting player's score.
module score_control
  import score_pkg::*;
#(
  parameter int         WIN_SCORE   = DEF_WIN_SCORE,
  parameter logic [3:0] RESTART_KEY = DEF_RESTART_KEY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         keypad_in,
  input  logic               whose,
  input  logic               right,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               fin,
  output logic               winner,
  output logic               judged,
  output logic               last_right
);

  localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic [3:0]         key_prev;
  logic               player_q;
  logic               verdict_q;
  logic               submit;
  logic               upd;
  logic               restart;
  logic               dec;
  logic [SCORE_W-1:0] next1, next2, new_score;

  assign submit    = (keypad_in != 4'd0) && (key_prev == 4'd0);
  assign upd       = (state == UPDATE);
  assign restart   = (state == GAME_OVER) && submit && (keypad_in == RESTART_KEY);
  assign new_score = player_q ? next2 : next1;

`ifdef SCORE_PENALTY_EN
  assign dec = ~verdict_q;
`else
  assign dec = 1'b0;
`endif

  score_counter u_cnt1 (
    .clk        (clk),
    .rst        (rst),
    .en         (upd && !player_q),
    .inc        (verdict_q),
    .dec        (dec),
    .clr        (restart),
    .count      (score1),
    .count_next (next1)
  );

  score_counter u_cnt2 (
    .clk        (clk),
    .rst        (rst),
    .en         (upd && player_q),
    .inc        (verdict_q),
    .dec        (dec),
    .clr        (restart),
    .count      (score2),
    .count_next (next2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_prev <= 4'd0;
    else     key_prev <= keypad_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      player_q   <= 1'b0;
      verdict_q  <= 1'b0;
      fin        <= 1'b0;
      winner     <= 1'b0;
      judged     <= 1'b0;
      last_right <= 1'b0;
    end else begin
      judged <= 1'b0;
      case (state)
        IDLE: begin
          if (submit) begin
            player_q <= whose;
            state    <= JUDGE;
          end
        end
        JUDGE: begin
          verdict_q <= right;
          state     <= UPDATE;
        end
        UPDATE: begin
          judged     <= 1'b1;
          last_right <= verdict_q;
          if (new_score >= WIN_Q) begin
            fin    <= 1'b1;
            winner <= player_q;
            state  <= GAME_OVER;
          end else begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (keypad_in == 4'd0) state <= IDLE;
        end
        GAME_OVER: begin
          // Scores stay frozen; only the restart code leaves this state.
          if (restart) begin
            fin        <= 1'b0;
            winner     <= 1'b0;
            last_right <= 1'b0;
            state      <= RELEASE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
